async_fifo_param: RTL and testbench

Parametrised dual-clock FIFO that carries DATA_W-bit words from the wr_clk domain to the rd_clk domain.
- Depth is 2**ADDR_W; entry count uses the full depth.
- Pointers cross domains as Gray code through a configurable-depth synchronizer.
- Adds per-domain fill counts, programmable almost-full/almost-empty, registered flags and error pulses.
- Used as the standard CDC buffer between streaming blocks.

---
 rtl/async_fifo_pkg.sv | 33 +++
 rtl/gray_sync.sv | 31 +++
 rtl/async_fifo_param.sv | 148 ++++++++++++++
 tb/tb_async_fifo_param.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and parameter sanity checks.
// Pure package, no state; no latency or backpressure of its own.
`timescale 1ns/100ps
package async_fifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        return (b ^ (b >> 1)) & width_mask(w);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & width_mask(w);
        b  = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    function automatic bit thresholds_ok(input int aempty_th, input int afull_th, input int addr_w);
        return (aempty_th < afull_th) && (afull_th <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// Latency STAGES clk edges; no backpressure, samples every edge.
`timescale 1ns/100ps
module gray_sync #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_param.sv
// Dual-clock FIFO, wr_clk -> rd_clk, Gray pointers; ASYNC_FIFO_FWFT_EN selects first-word-fall-through.
// Latency: SYNC_STAGES+1 rd_clk edges to clear empty (+1 edge to present data; FWFT one more).
// Backpressure: full/empty are pessimistic; writes while full and reads while empty are dropped and flagged.
`timescale 1ns/100ps
module async_fifo_param
    import async_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 6,
    parameter int AEMPTY_TH   = 1
) (
    input  logic              wr_clk,
    input  logic              rd_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    if (!thresholds_ok(AEMPTY_TH, AFULL_TH, ADDR_W)) begin : g_bad_thresholds
        $error("async_fifo_param: thresholds must satisfy AEMPTY_TH < AFULL_TH <= 2**ADDR_W");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("async_fifo_param: SYNC_STAGES out of range");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rgray_sync, rsync_bin, wr_count_next;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wgray_sync, wsync_bin, rd_count_next;
    logic [PW-1:0] out_extra;
    logic          wr_acc, mem_rd, mem_empty, valid_next, underflow_next;

    // ---------------- write domain ----------------
    assign rsync_bin = PW'(gray2bin(32'(rgray_sync), PW));

    always_comb begin
        wr_acc        = wr_en && !full;
        wbin_next     = wbin + PW'(wr_acc);
        wgray_next    = PW'(bin2gray(32'(wbin_next), PW));
        wr_count_next = wbin_next - rsync_bin;
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wbin        <= '0;
            wgray       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            // Full when the write pointer is one lap ahead: top two Gray bits inverted.
            full        <= (wgray_next == {~rgray_sync[ADDR_W:ADDR_W-1], rgray_sync[ADDR_W-2:0]});
            almost_full <= (wr_count_next >= AFULL_C);
            wr_count    <= wr_count_next;
            overflow    <= wr_en && full;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_acc) begin
            mem[wbin[ADDR_W-1:0]] <= wdata;
        end
    end

    gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk (wr_clk),
        .rst (rst),
        .d   (rgray),
        .q   (rgray_sync)
    );

    gray_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk (rd_clk),
        .rst (rst),
        .d   (wgray),
        .q   (wgray_sync)
    );

    // ---------------- read domain ----------------
    assign wsync_bin = PW'(gray2bin(32'(wgray_sync), PW));

`ifdef ASYNC_FIFO_FWFT_EN
    // Output register refills from memory whenever it is free or being popped.
    assign mem_rd         = !mem_empty && (!valid || rd_en);
    assign valid_next     = mem_rd || (valid && !rd_en);
    assign out_extra      = PW'(valid_next);
    assign underflow_next = rd_en && !valid;
    assign empty          = !valid;
`else
    assign mem_rd         = rd_en && !mem_empty;
    assign valid_next     = mem_rd;
    assign out_extra      = '0;
    assign underflow_next = rd_en && mem_empty;
    assign empty          = mem_empty;
`endif

    always_comb begin
        rbin_next     = rbin + PW'(mem_rd);
        rgray_next    = PW'(bin2gray(32'(rbin_next), PW));
        rd_count_next = wsync_bin - rbin_next + out_extra;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rbin         <= '0;
            rgray        <= '0;
            mem_empty    <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            rdata        <= '0;
            valid        <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            mem_empty    <= (rgray_next == wgray_sync);
            almost_empty <= (rd_count_next <= AEMPTY_C);
            rd_count     <= rd_count_next;
            valid        <= valid_next;
            underflow    <= underflow_next;
            if (mem_rd) begin
                rdata <= mem[rbin[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_param.sv
// Scoreboard bench for async_fifo_param: wr_clk 10 ns, rd_clk 17 ns, second instance with SYNC_STAGES=3.
`timescale 1ns/100ps
module tb_async_fifo_param;

    logic       wr_clk = 1'b0;
    logic       rd_clk = 1'b0;
    logic       rst    = 1'b1;
    logic       wr_en  = 1'b0, rd_en = 1'b0;
    logic [7:0] wdata  = '0;
    logic       full, almost_full, overflow, valid, empty, almost_empty, underflow;
    logic [3:0] wr_count, rd_count;
    logic [7:0] rdata;

    logic       wr_en_b = 1'b0, rd_en_b = 1'b0;
    logic [7:0] wdata_b = '0;
    logic       full_b, almost_full_b, overflow_b, valid_b, empty_b, almost_empty_b, underflow_b;
    logic [3:0] wr_count_b, rd_count_b;
    logic [7:0] rdata_b;

    logic [7:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    int ovf_seen = 0;
    int und_seen = 0;
    bit mon_on   = 1'b0;

    always #5   wr_clk = ~wr_clk;
    always #8.5 rd_clk = ~rd_clk;

    async_fifo_param #(.DATA_W(8), .ADDR_W(3), .SYNC_STAGES(2), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
        .wr_en(wr_en), .wdata(wdata), .full(full), .almost_full(almost_full),
        .wr_count(wr_count), .overflow(overflow),
        .rd_en(rd_en), .rdata(rdata), .valid(valid), .empty(empty),
        .almost_empty(almost_empty), .rd_count(rd_count), .underflow(underflow)
    );

    async_fifo_param #(.DATA_W(8), .ADDR_W(3), .SYNC_STAGES(3), .AFULL_TH(6), .AEMPTY_TH(1)) dut_b (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
        .wr_en(wr_en_b), .wdata(wdata_b), .full(full_b), .almost_full(almost_full_b),
        .wr_count(wr_count_b), .overflow(overflow_b),
        .rd_en(rd_en_b), .rdata(rdata_b), .valid(valid_b), .empty(empty_b),
        .almost_empty(almost_empty_b), .rd_count(rd_count_b), .underflow(underflow_b)
    );

    always @(negedge wr_clk) if (mon_on && overflow === 1'b1) ovf_seen++;
    always @(negedge rd_clk) if (mon_on && underflow === 1'b1) und_seen++;

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
        exp_q.delete();
        repeat (6) @(posedge rd_clk);
        @(negedge wr_clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({full, almost_full, wr_count, overflow} !== 7'b0) begin
            failures++; $display("FAIL reset_wr_side got=%b exp=%b", {full, almost_full, wr_count, overflow}, 7'b0);
        end
        checks++;
        if ({empty, almost_empty, rd_count, valid, underflow} !== 8'b1100_0000) begin
            failures++; $display("FAIL reset_rd_side got=%b exp=%b", {empty, almost_empty, rd_count, valid, underflow}, 8'b1100_0000);
        end
        checks++;
        if (rdata !== 8'h00) begin
            failures++; $display("FAIL reset_rdata got=%h exp=00", rdata);
        end
        checks++;
        if ({empty_b, full_b, valid_b} !== 3'b100) begin
            failures++; $display("FAIL reset_inst_b got=%b exp=100", {empty_b, full_b, valid_b});
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            @(negedge wr_clk);
            wr_en = 1'b1; wdata = 8'(i); exp_q.push_back(8'(i));
            @(posedge wr_clk); #1;
            checks++;
            if ({full, almost_full, wr_count} !== {(i == 8), (i >= 6), 4'(i)}) begin
                failures++;
                $display("FAIL fill_flags write=%0d got full=%b afull=%b cnt=%0d exp full=%b afull=%b cnt=%0d",
                         i, full, almost_full, wr_count, (i == 8), (i >= 6), i);
            end
        end
        @(negedge wr_clk);
        wdata = 8'hFF;
        @(posedge wr_clk); #1;
        checks++;
        if ({overflow, full, wr_count} !== {1'b1, 1'b1, 4'd8}) begin
            failures++; $display("FAIL overflow_pulse got ovf=%b full=%b cnt=%0d exp 1 1 8", overflow, full, wr_count);
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
        @(posedge wr_clk); #1;
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL overflow_one_cycle got=%b exp=0", overflow);
        end
    endtask

    task automatic test_drain();
        logic [7:0] e;
        repeat (4) @(posedge rd_clk);
        #1;
        checks++;
        if ({empty, almost_empty, rd_count} !== {1'b0, 1'b0, 4'd8}) begin
            failures++; $display("FAIL drain_pre got empty=%b aempty=%b cnt=%0d exp 0 0 8", empty, almost_empty, rd_count);
        end
        for (int i = 1; i <= 9; i++) begin
            @(negedge rd_clk);
            rd_en = 1'b1;
            @(posedge rd_clk); #1;
            checks++;
            if (i <= 8) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                if ({valid, rdata, empty} !== {1'b1, e, (i == 8)}) begin
                    failures++;
                    $display("FAIL drain_word read=%0d got valid=%b data=%h empty=%b exp 1 %h %b",
                             i, valid, rdata, empty, e, (i == 8));
                end
            end else if ({valid, underflow, rdata} !== {1'b0, 1'b1, 8'h08}) begin
                failures++; $display("FAIL underflow_pulse got valid=%b udf=%b data=%h exp 0 1 08", valid, underflow, rdata);
            end
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
        @(posedge rd_clk); #1;
        checks++;
        if ({underflow, valid} !== 2'b00) begin
            failures++; $display("FAIL underflow_one_cycle got=%b exp=00", {underflow, valid});
        end
        repeat (4) @(posedge wr_clk);
        #1;
        checks++;
        if ({full, almost_full, wr_count} !== 6'b0) begin
            failures++; $display("FAIL drain_wr_side got full=%b afull=%b cnt=%0d exp 0 0 0", full, almost_full, wr_count);
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got  = 0;
        ovf_seen = 0; und_seen = 0; mon_on = 1'b1;
        fork
            begin
                for (int cyc = 0; cyc < 4000 && sent < 100; cyc++) begin
                    @(negedge wr_clk);
                    if (!full && $urandom_range(0, 3) != 0) begin
                        wr_en = 1'b1; wdata = 8'(sent); exp_q.push_back(8'(sent)); sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                logic [7:0] e;
                for (int cyc = 0; cyc < 4000 && got < 100; cyc++) begin
                    @(negedge rd_clk);
                    rd_en = !empty && ($urandom_range(0, 2) != 0);
                    @(posedge rd_clk); #1;
                    checks++;
                    if (valid !== rd_en) begin
                        failures++; $display("FAIL stream_valid got=%b exp=%b", valid, rd_en);
                    end
                    if (valid === 1'b1) begin
                        got++;
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                        checks++;
                        if (rdata !== e) begin
                            failures++; $display("FAIL stream_data got=%h exp=%h", rdata, e);
                        end
                    end
                end
                @(negedge rd_clk);
                rd_en = 1'b0;
            end
        join
        mon_on = 1'b0;
        checks++;
        if (got != 100) begin
            failures++; $display("FAIL stream_count got=%0d exp=100", got);
        end
        checks++;
        if (ovf_seen != 0 || und_seen != 0) begin
            failures++; $display("FAIL stream_errors got ovf=%0d udf=%0d exp 0 0", ovf_seen, und_seen);
        end
    endtask

    task automatic test_latency();
        int na = 0;
        int nb = 0;
        logic [7:0] e;
        repeat (5) @(posedge rd_clk);
        @(negedge wr_clk);
        wr_en = 1'b1; wdata = 8'h5A; wr_en_b = 1'b1; wdata_b = 8'h5A; exp_q.push_back(8'h5A);
        @(posedge wr_clk); #1;
        wr_en = 1'b0; wr_en_b = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge rd_clk); #1;
            if (na == 0 && empty === 1'b0) na = n;
            if (nb == 0 && empty_b === 1'b0) nb = n;
        end
        checks++;
        if (na != 3) begin
            failures++; $display("FAIL latency_sync2 got=%0d edges exp=3", na);
        end
        checks++;
        if (nb != 4) begin
            failures++; $display("FAIL latency_sync3 got=%0d edges exp=4", nb);
        end
        @(negedge rd_clk);
        rd_en = 1'b1; rd_en_b = 1'b1;
        @(posedge rd_clk); #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if ({valid, rdata} !== {1'b1, e}) begin
            failures++; $display("FAIL latency_data got valid=%b data=%h exp 1 %h", valid, rdata, e);
        end
        checks++;
        if ({valid_b, rdata_b} !== {1'b1, 8'h5A}) begin
            failures++; $display("FAIL latency_data_b got valid=%b data=%h exp 1 5a", valid_b, rdata_b);
        end
        @(negedge rd_clk);
        rd_en = 1'b0; rd_en_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic [7:0] e;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            wr_en = 1'b1; wdata = 8'h10 + 8'(i);
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
        repeat (4) @(posedge rd_clk);
        #1;
        checks++;
        if (rd_count !== 4'd5) begin
            failures++; $display("FAIL midreset_prefill got=%0d exp=5", rd_count);
        end
        rst = 1'b1;
        exp_q.delete();
        repeat (6) @(posedge rd_clk);
        @(negedge wr_clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({full, wr_count, empty, rd_count, valid} !== {1'b0, 4'd0, 1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_state got full=%b wcnt=%0d empty=%b rcnt=%0d valid=%b exp 0 0 1 0 0",
                     full, wr_count, empty, rd_count, valid);
        end
        @(negedge wr_clk);
        wr_en = 1'b1; wdata = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge wr_clk);
        wr_en = 1'b0;
        for (int n = 0; n < 10 && seen == 0; n++) begin
            @(posedge rd_clk); #1;
            if (empty === 1'b0) seen = 1;
        end
        checks++;
        if (seen != 1) begin
            failures++; $display("FAIL midreset_arrival got empty=%b exp=0 within 10 edges", empty);
        end
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(posedge rd_clk); #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if ({valid, rdata, empty} !== {1'b1, e, 1'b1}) begin
            failures++; $display("FAIL midreset_word got valid=%b data=%h empty=%b exp 1 %h 1", valid, rdata, empty, e);
        end
        @(posedge rd_clk); #1;
        checks++;
        if ({valid, underflow} !== 2'b01) begin
            failures++; $display("FAIL midreset_only_word got valid=%b udf=%b exp 0 1", valid, underflow);
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
    endtask

    task automatic test_fwft();
        int n_vld = 0;
        logic [7:0] e;
        @(negedge wr_clk);
        wr_en = 1'b1; wdata = 8'h3C; exp_q.push_back(8'h3C);
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        for (int n = 1; n <= 10 && n_vld == 0; n++) begin
            @(posedge rd_clk); #1;
            if (valid === 1'b1) n_vld = n;
        end
        checks++;
        if (n_vld != 4) begin
            failures++; $display("FAIL fwft_latency got=%0d edges exp=4", n_vld);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if ({valid, rdata, empty, rd_count} !== {1'b1, e, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL fwft_head got valid=%b data=%h empty=%b cnt=%0d exp 1 %h 0 1", valid, rdata, empty, rd_count, e);
        end
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(posedge rd_clk); #1;
        checks++;
        if ({valid, empty, rd_count} !== {1'b0, 1'b1, 4'd0}) begin
            failures++; $display("FAIL fwft_pop got valid=%b empty=%b cnt=%0d exp 0 1 0", valid, empty, rd_count);
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef ASYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_fill();
        test_drain();
        test_stream();
        test_latency();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
